uart_lbus_master: RTL and testbench
===================================

# uart_lbus_master

Command bridge: takes a byte stream from the UART receiver, decodes fixed-length read/write frames, and drives them as an initiator on the 32-bit local bus. It returns the response bytes on a ready/valid byte stream to the UART transmitter. It sits between the UART byte engine and the local-bus interconnect, alongside the CPU, and gives host-side debug and boot access to the peripheral registers and memory.

## Interface
- ADDR_W, 32, local-bus address width; framing requires exactly 32
- DATA_W, 32, local-bus data width; framing requires exactly 32
- STRB_W, DATA_W/8, byte-strobe width
- BYTE_TO, 2_700_000, inter-byte timeout in clk cycles (100 ms at 27 MHz)
- BUS_TO, 255, cycles to wait for wready/rvalid before aborting
- clk  input  1  system clock; the only clock
- rst  input  1  reset, asynchronous, active-low
- rx_data  input  8  received byte
- rx_valid  input  1  one-cycle strobe, rx_data valid; no backpressure
- tx_data  output  8  response byte
- tx_valid  output  1  response byte valid
- tx_ready  input  1  transmitter accepts byte
- waddr  output  ADDR_W  write address
- wdata  output  DATA_W  write data
- wen  output  1  write request
- wstrb  output  STRB_W  write strobes, always all ones during wen
- wready  input  1  write accepted
- raddr  output  ADDR_W  read address
- ren  output  1  read request
- rdata  input  DATA_W  read data
- rvalid  input  1  read data valid
- err  output  1  one-cycle pulse on bad command, timeout or dropped byte

## Operation
- Frame format: command byte, then 4 address bytes LSB first. A write frame adds 4 data bytes LSB first.
- Command codes: 0x57 'W' (write) and 0x52 'R' (read).
- States and transitions:
  - IDLE: on rx_valid with 0x57 or 0x52, latch the command, clear byte_cnt, go to ADDR. Any other byte sends 0x3F '?' (via RESP) and pulses err.
  - ADDR: each rx_valid shifts into addr[8*byte_cnt +: 8]. After the 4th byte, a write goes to DATA and a read goes to RD.
  - DATA: collects 4 bytes the same way, then goes to WR.
  - WR: hold wen=1 with waddr/wdata/wstrb=4'hF stable until the cycle wready=1, then load 0x4B 'K' and go to RESP.
  - RD: hold ren=1 with raddr stable until the cycle rvalid=1. Capture rdata in that cycle, load its 4 bytes LSB first, go to RESP.
  - RESP: present queued bytes on tx_valid/tx_data. Advance on tx_valid&&tx_ready. Return to IDLE after the last byte.
- Inter-byte timeout: in ADDR or DATA, if BYTE_TO cycles pass without rx_valid, discard the frame, pulse err and return to IDLE with no response.
- Bus timeout: in WR or RD, if BUS_TO cycles pass without wready/rvalid, drop wen/ren, pulse err and send 0x45 'E'.
- Dropped bytes: rx_valid in WR, RD or RESP discards the byte and pulses err.
- The shared timeout counter reloads on every state entry and on every accepted byte.

## Timing
- Reset values: all outputs 0 (wen, ren, tx_valid, err, waddr, raddr, wdata, tx_data); wstrb 0; state IDLE.
- Reset asserted mid-transaction aborts immediately, with no response after release.
- wen and ren are asserted the cycle after the last frame byte is accepted, and deassert the cycle after the wready/rvalid cycle.
- wready or rvalid high in the first request cycle completes the access in 1 cycle.
- tx_valid rises the cycle after the bus handshake completes.
- tx_data is stable while tx_valid && !tx_ready. tx_valid is never withdrawn before acceptance.
- Write latency, best case: last rx byte at cycle 0 → wen cycle 1 → tx_valid 'K' cycle 2.
- byte_cnt is 2 bits and wraps 3→0 exactly at the state change.
- The timeout counter is sized $clog2(max(BYTE_TO,BUS_TO)+1) and counts down. Expiry occurs at count 0.
- A timeout and rx_valid arriving in the same cycle: rx_valid wins and the counter reloads.

## Structure
- Package uart_lbus_pkg holds:
  - command codes CMD_WR=8'h57 and CMD_RD=8'h52
  - response codes RSP_OK=8'h4B, RSP_ERR=8'h45 and RSP_BAD=8'h3F
  - the state enum IDLE, ADDR, DATA, WR, RD, RESP
- One sub-module, uart_lbus_timer: loadable down-counter with a reload value input and a zero flag, shared by both timeouts.
- The response byte queue (up to 4 bytes plus a count) stays in the top level.

## Test plan
- Write, bytes 57 10 00 00 40 EF BE AD DE, wready high after 3 cycles → one wen burst with waddr=0x4000_0010, wdata=0xDEADBEEF, wstrb=F; tx emits 4B.
- Read, bytes 52 04 00 00 40, rvalid at cycle 2 with rdata=0x1234_5678 → ren for 2 cycles; tx emits 78 56 34 12 in order under random tx_ready stalls.
- Byte 0x41 in IDLE → err pulse, tx emits 3F, no bus activity.
- Bus timeout: write frame with wready tied low → wen held BUS_TO cycles then dropped, err pulse, tx emits 45.
- Inter-byte timeout with BYTE_TO=100: 52 00, then 100 idle cycles → err pulse, return to IDLE, no tx. A following full read frame completes normally.
- rst low mid-RD with ren=1 → ren, tx_valid and err are 0 asynchronously. After release, the block responds to a new frame correctly.

Source files
------------

// File: rtl/uart_lbus_pkg.sv
// Shared command/response codes and FSM state encoding for the UART-to-local-bus bridge.
package uart_lbus_pkg;

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h45;
  localparam logic [7:0] RSP_BAD = 8'h3F;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    WR,
    RD,
    RESP
  } state_t;

endpackage

// File: rtl/uart_lbus_timer.sv
// Loadable down-counter with a zero flag; shared by the inter-byte and bus timeouts.
module uart_lbus_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (cnt_reg != '0) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign zero = (cnt_reg == '0);

endmodule

// File: rtl/uart_lbus_master.sv
// Decodes fixed-length 'W'/'R' frames from the UART byte stream, runs them on the
// local bus and streams the response bytes back to the UART transmitter.
module uart_lbus_master
  import uart_lbus_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int STRB_W  = DATA_W / 8,
  parameter int BYTE_TO = 2_700_000,
  parameter int BUS_TO  = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic              wen,
  output logic [STRB_W-1:0] wstrb,
  input  logic              wready,
  output logic [ADDR_W-1:0] raddr,
  output logic              ren,
  input  logic [DATA_W-1:0] rdata,
  input  logic              rvalid,
  output logic              err
);

  localparam int TO_MAX = (BYTE_TO > BUS_TO) ? BYTE_TO : BUS_TO;
  localparam int TW     = $clog2(TO_MAX + 1);
  // Reload with N-1 so expiry lands exactly N cycles after the reload.
  localparam logic [TW-1:0] BYTE_LOAD = TW'(BYTE_TO - 1);
  localparam logic [TW-1:0] BUS_LOAD  = TW'(BUS_TO - 1);

  state_t            state_reg, state_next;
  logic [1:0]        byte_cnt_reg, byte_cnt_next;
  logic              is_wr_reg, is_wr_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] data_reg, data_next;
  logic [DATA_W-1:0] resp_q_reg, resp_q_next;
  logic [2:0]        resp_left_reg, resp_left_next;
  logic              err_reg, err_next;
  logic              rx_accept;
  logic              to_load;
  logic [TW-1:0]     to_load_val;
  logic              to_zero;

  uart_lbus_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (to_load),
    .load_val (to_load_val),
    .zero     (to_zero)
  );

  assign to_load     = (state_next != state_reg) || rx_accept;
  assign to_load_val = (state_next == WR || state_next == RD) ? BUS_LOAD : BYTE_LOAD;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      byte_cnt_reg  <= '0;
      is_wr_reg     <= 1'b0;
      addr_reg      <= '0;
      data_reg      <= '0;
      resp_q_reg    <= '0;
      resp_left_reg <= '0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      byte_cnt_reg  <= byte_cnt_next;
      is_wr_reg     <= is_wr_next;
      addr_reg      <= addr_next;
      data_reg      <= data_next;
      resp_q_reg    <= resp_q_next;
      resp_left_reg <= resp_left_next;
      err_reg       <= err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    byte_cnt_next  = byte_cnt_reg;
    is_wr_next     = is_wr_reg;
    addr_next      = addr_reg;
    data_next      = data_reg;
    resp_q_next    = resp_q_reg;
    resp_left_next = resp_left_reg;
    err_next       = 1'b0;
    rx_accept      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (rx_valid) begin
          if (rx_data == CMD_WR || rx_data == CMD_RD) begin
            is_wr_next    = (rx_data == CMD_WR);
            byte_cnt_next = '0;
            state_next    = ADDR;
          end else begin
            resp_q_next    = DATA_W'(RSP_BAD);
            resp_left_next = 3'd1;
            err_next       = 1'b1;
            state_next     = RESP;
          end
        end
      end
      ADDR: begin
        if (rx_valid) begin
          rx_accept = 1'b1;
          addr_next[{byte_cnt_reg, 3'b000} +: 8] = rx_data;
          byte_cnt_next = byte_cnt_reg + 2'd1;
          if (byte_cnt_reg == 2'd3) state_next = is_wr_reg ? DATA : RD;
        end else if (to_zero) begin
          err_next   = 1'b1;
          state_next = IDLE;
        end
      end
      DATA: begin
        if (rx_valid) begin
          rx_accept = 1'b1;
          data_next[{byte_cnt_reg, 3'b000} +: 8] = rx_data;
          byte_cnt_next = byte_cnt_reg + 2'd1;
          if (byte_cnt_reg == 2'd3) state_next = WR;
        end else if (to_zero) begin
          err_next   = 1'b1;
          state_next = IDLE;
        end
      end
      WR: begin
        if (wready) begin
          resp_q_next    = DATA_W'(RSP_OK);
          resp_left_next = 3'd1;
          state_next     = RESP;
        end else if (to_zero) begin
          resp_q_next    = DATA_W'(RSP_ERR);
          resp_left_next = 3'd1;
          err_next       = 1'b1;
          state_next     = RESP;
        end
      end
      RD: begin
        if (rvalid) begin
          resp_q_next    = rdata;
          resp_left_next = 3'd4;
          state_next     = RESP;
        end else if (to_zero) begin
          resp_q_next    = DATA_W'(RSP_ERR);
          resp_left_next = 3'd1;
          err_next       = 1'b1;
          state_next     = RESP;
        end
      end
      RESP: begin
        if (tx_ready) begin
          resp_q_next    = resp_q_reg >> 8;
          resp_left_next = resp_left_reg - 3'd1;
          if (resp_left_reg == 3'd1) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // Bytes arriving while the bus or the transmitter is busy are lost.
    if (rx_valid && (state_reg == WR || state_reg == RD || state_reg == RESP)) err_next = 1'b1;
  end

  assign wen      = (state_reg == WR);
  assign ren      = (state_reg == RD);
  assign wstrb    = {STRB_W{wen}};
  assign waddr    = addr_reg;
  assign raddr    = addr_reg;
  assign wdata    = data_reg;
  assign tx_valid = (state_reg == RESP);
  assign tx_data  = resp_q_reg[7:0];
  assign err      = err_reg;

endmodule

// File: tb/tb_uart_lbus_master.sv
// Directed bench for uart_lbus_master: write, read with tx stalls, bad command,
// bus and inter-byte timeouts, dropped byte and asynchronous reset.
module tb_uart_lbus_master;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic        wen;
  logic [3:0]  wstrb;
  logic        wready;
  logic [31:0] raddr;
  logic        ren;
  logic [31:0] rdata;
  logic        rvalid;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [7:0] wr_frame [9] = '{8'h57, 8'h10, 8'h00, 8'h00, 8'h40, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
  logic [7:0] rd_frame [5] = '{8'h52, 8'h04, 8'h00, 8'h00, 8'h40};

  uart_lbus_master #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .STRB_W  (4),
    .BYTE_TO (100),
    .BUS_TO  (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .waddr    (waddr),
    .wdata    (wdata),
    .wen      (wen),
    .wstrb    (wstrb),
    .wready   (wready),
    .raddr    (raddr),
    .ren      (ren),
    .rdata    (rdata),
    .rvalid   (rvalid),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Starts and ends on a falling edge; the byte is taken on the rising edge in between.
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic test_reset;
    checks++;
    if ({wen, ren, tx_valid, err} !== 4'b0000 || waddr !== 32'h0 || raddr !== 32'h0 ||
        wdata !== 32'h0 || tx_data !== 8'h00 || wstrb !== 4'h0) begin
      errors++;
      $display("FAIL reset_values: wen=%b ren=%b tx_valid=%b err=%b waddr=%h raddr=%h wdata=%h tx_data=%h wstrb=%h, required all zero",
               wen, ren, tx_valid, err, waddr, raddr, wdata, tx_data, wstrb);
    end
    $display("reset: outputs checked while rst low");
  endtask

  task automatic test_write;
    int n;
    for (int i = 0; i < 9; i++) send_byte(wr_frame[i]);
    checks++;
    if (wen !== 1'b1) begin errors++; $display("FAIL wr_wen_latency: wen=%b required 1", wen); end
    checks++;
    if (waddr !== 32'h4000_0010 || wdata !== 32'hDEAD_BEEF || wstrb !== 4'hF) begin
      errors++;
      $display("FAIL wr_bus_fields: waddr=%h wdata=%h wstrb=%h required 40000010 deadbeef f", waddr, wdata, wstrb);
    end
    n = 0;
    while (wen === 1'b1 && n < 50) begin
      n++;
      wready = (n == 3);
      @(negedge clk);
    end
    wready = 1'b0;
    checks++;
    if (n !== 3) begin errors++; $display("FAIL wr_wen_cycles: got %0d required 3", n); end
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h4B) begin
      errors++;
      $display("FAIL wr_resp: tx_valid=%b tx_data=%h required 1 4b", tx_valid, tx_data);
    end
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    checks++;
    if (tx_valid !== 1'b0) begin errors++; $display("FAIL wr_resp_done: tx_valid=%b required 0", tx_valid); end
    $display("write: addr 40000010 data deadbeef, wen %0d cycles", n);
  endtask

  task automatic test_read_stall;
    int n;
    int got;
    logic [7:0] bytes [4];
    logic [7:0] exp [4] = '{8'h78, 8'h56, 8'h34, 8'h12};
    logic       held;
    logic [7:0] held_data;
    for (int i = 0; i < 5; i++) send_byte(rd_frame[i]);
    checks++;
    if (ren !== 1'b1 || raddr !== 32'h4000_0004) begin
      errors++;
      $display("FAIL rd_req: ren=%b raddr=%h required 1 40000004", ren, raddr);
    end
    n = 0;
    while (ren === 1'b1 && n < 50) begin
      n++;
      rvalid = (n == 2);
      rdata  = (n == 2) ? 32'h1234_5678 : 32'h0;
      @(negedge clk);
    end
    rvalid = 1'b0;
    checks++;
    if (n !== 2) begin errors++; $display("FAIL rd_ren_cycles: got %0d required 2", n); end
    checks++;
    if (tx_valid !== 1'b1) begin errors++; $display("FAIL rd_tx_rise: tx_valid=%b required 1", tx_valid); end
    got  = 0;
    n    = 0;
    held = 1'b0;
    held_data = 8'h00;
    while (got < 4 && n < 200) begin
      n++;
      if (tx_valid === 1'b1) begin
        if (held && tx_data !== held_data) begin
          checks++;
          errors++;
          $display("FAIL rd_tx_stable: tx_data=%h required %h", tx_data, held_data);
        end
        tx_ready = ($urandom_range(0, 1) == 1);
        if (tx_ready) begin
          bytes[got] = tx_data;
          got++;
          held = 1'b0;
        end else begin
          held = 1'b1;
          held_data = tx_data;
        end
      end else begin
        tx_ready = 1'b0;
      end
      @(negedge clk);
    end
    tx_ready = 1'b0;
    checks++;
    if (got !== 4) begin
      errors++;
      $display("FAIL rd_tx_count: got %0d bytes required 4", got);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (bytes[i] !== exp[i]) begin
          errors++;
          $display("FAIL rd_byte%0d: got %h required %h", i, bytes[i], exp[i]);
        end
      end
    end
    checks++;
    if (tx_valid !== 1'b0) begin errors++; $display("FAIL rd_resp_done: tx_valid=%b required 0", tx_valid); end
    $display("read: addr 40000004, ren %0d cycles, %0d bytes under stalls", 2, got);
  endtask

  task automatic test_bad_cmd;
    send_byte(8'h41);
    checks++;
    if (err !== 1'b1 || tx_valid !== 1'b1 || tx_data !== 8'h3F || wen !== 1'b0 || ren !== 1'b0) begin
      errors++;
      $display("FAIL bad_cmd: err=%b tx_valid=%b tx_data=%h wen=%b ren=%b required 1 1 3f 0 0",
               err, tx_valid, tx_data, wen, ren);
    end
    // A byte arriving while the response is stalled is dropped.
    send_byte(8'h52);
    checks++;
    if (err !== 1'b1 || tx_valid !== 1'b1 || tx_data !== 8'h3F) begin
      errors++;
      $display("FAIL dropped_byte: err=%b tx_valid=%b tx_data=%h required 1 1 3f", err, tx_valid, tx_data);
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL err_pulse_width: err=%b required 0", err); end
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    checks++;
    if (tx_valid !== 1'b0) begin errors++; $display("FAIL bad_cmd_done: tx_valid=%b required 0", tx_valid); end
    $display("bad_cmd: 41 answered with 3f, dropped byte flagged");
  endtask

  task automatic test_bus_timeout;
    int n;
    for (int i = 0; i < 9; i++) send_byte(wr_frame[i]);
    n = 0;
    while (wen === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n !== 16) begin errors++; $display("FAIL bus_to_cycles: wen held %0d required 16", n); end
    checks++;
    if (err !== 1'b1 || tx_valid !== 1'b1 || tx_data !== 8'h45) begin
      errors++;
      $display("FAIL bus_to_resp: err=%b tx_valid=%b tx_data=%h required 1 1 45", err, tx_valid, tx_data);
    end
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    $display("bus_timeout: wen held %0d cycles, response 45", n);
  endtask

  task automatic test_byte_timeout;
    int n;
    int quiet;
    send_byte(8'h52);
    send_byte(8'h00);
    n = 0;
    quiet = 1;
    while (err !== 1'b1 && n < 300) begin
      if (tx_valid !== 1'b0) quiet = 0;
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== 100) begin errors++; $display("FAIL byte_to_cycles: err after %0d required 100", n); end
    @(negedge clk);
    checks++;
    if (quiet != 1 || tx_valid !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL byte_to_silent: quiet=%0d tx_valid=%b err=%b required 1 0 0", quiet, tx_valid, err);
    end
    for (int i = 0; i < 5; i++) send_byte(rd_frame[i]);
    rvalid = 1'b1;
    rdata  = 32'hCAFE_F00D;
    @(negedge clk);
    rvalid = 1'b0;
    tx_ready = 1'b1;
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h0D) begin
      errors++;
      $display("FAIL byte_to_recover: tx_valid=%b tx_data=%h required 1 0d", tx_valid, tx_data);
    end
    repeat (4) @(negedge clk);
    tx_ready = 1'b0;
    checks++;
    if (tx_valid !== 1'b0) begin errors++; $display("FAIL byte_to_recover_done: tx_valid=%b required 0", tx_valid); end
    $display("byte_timeout: err after %0d idle cycles, next read ok", n);
  endtask

  task automatic test_async_reset;
    int noisy;
    for (int i = 0; i < 5; i++) send_byte(rd_frame[i]);
    checks++;
    if (ren !== 1'b1) begin errors++; $display("FAIL rst_pre_ren: ren=%b required 1", ren); end
    #1 rst = 1'b0;
    #1;
    checks++;
    if (ren !== 1'b0 || tx_valid !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL rst_async: ren=%b tx_valid=%b err=%b required 0 0 0", ren, tx_valid, err);
    end
    @(negedge clk);
    rst = 1'b1;
    noisy = 0;
    repeat (5) begin
      @(negedge clk);
      if (tx_valid !== 1'b0 || ren !== 1'b0 || err !== 1'b0) noisy = 1;
    end
    checks++;
    if (noisy != 0) begin errors++; $display("FAIL rst_no_resp: activity after release"); end
    wready = 1'b1;
    for (int i = 0; i < 9; i++) send_byte(wr_frame[i]);
    checks++;
    if (wen !== 1'b1 || waddr !== 32'h4000_0010) begin
      errors++;
      $display("FAIL rst_recover_wen: wen=%b waddr=%h required 1 40000010", wen, waddr);
    end
    @(negedge clk);
    wready = 1'b0;
    checks++;
    if (wen !== 1'b0 || tx_valid !== 1'b1 || tx_data !== 8'h4B) begin
      errors++;
      $display("FAIL rst_recover_resp: wen=%b tx_valid=%b tx_data=%h required 0 1 4b", wen, tx_valid, tx_data);
    end
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    $display("async_reset: ren cleared, single-cycle write afterwards");
  endtask

  initial begin
    rst      = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    wready   = 1'b0;
    rdata    = 32'h0;
    rvalid   = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b1;
    @(negedge clk);
    test_write();
    test_read_stall();
    test_bad_cmd();
    test_bus_timeout();
    test_byte_timeout();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
